sdram_dq_path: RTL and testbench
================================

Name: sdram_dq_path

Overview:
- Parametrised SDRAM data path that sits between the AHB-Lite slave and the SDRAM pins, alongside the SDRAM command FSM.
- Each AHB word becomes RATIO = DATA_WIDTH/DQ_WIDTH DQ beats, with per-beat DQM generated from the byte strobes.
- Read beats are captured after a programmable CAS latency and reassembled into one word.
- The block owns DQ tri-state timing and bus turnaround, and tells the FSM when a new READ or WRITE may be issued.

Parameters:
- DATA_WIDTH, 32, AHB data width; must be a multiple of 8.
- DQ_WIDTH, 16, SDRAM DQ width; must divide DATA_WIDTH, with RATIO in {1,2,4}.
- CAS_LATENCY, 2, SDRAM CL in cycles; legal values 2 or 3.

Ports:
- HCLK  input  1  system clock
- HRESETn  input  1  asynchronous active-low reset
- cmd_write_i  input  1  one-cycle pulse: FSM issues WRITE; the command reaches the pins next cycle
- cmd_read_i  input  1  one-cycle pulse: FSM issues READ; the command reaches the pins next cycle
- wr_data_i  input  DATA_WIDTH  write word, sampled when cmd_write_i is high
- wr_strb_i  input  DATA_WIDTH/8  byte enables, sampled with wr_data_i
- wr_ready_o  output  1  a WRITE may be issued this cycle
- rd_ready_o  output  1  a READ may be issued this cycle
- rd_data_o  output  DATA_WIDTH  assembled read word
- rd_valid_o  output  1  one-cycle pulse; rd_data_o is valid
- err_o  output  1  sticky: a command was pulsed while not ready; cleared only by reset
- SDRAM_DQ  inout  DQ_WIDTH  physical data bus
- SDRAM_DQM  output  DQ_WIDTH/8  byte mask, active high

Behaviour:
- Clock and reset: one clock HCLK; reset HRESETn is asynchronous and active-low.
- Reset values:
  - DQ output enable is 0, so SDRAM_DQ is high-Z immediately on reset, not at the next edge.
  - SDRAM_DQM is all-ones.
  - rd_data_o = 0, rd_valid_o = 0, err_o = 0.
  - wr_ready_o = 1, rd_ready_o = 1.
  - All internal counters and pipelines are cleared.
  - Reset in mid-operation abandons any in-flight beats; nothing is emitted after release.
- Write path (cmd_write_i at cycle N):
  - Word and strobes are latched into a shift register.
  - Beat k (k = 0..RATIO-1) drives DQ[k*DQ_WIDTH +: DQ_WIDTH] on SDRAM_DQ during cycle N+1+k.
  - SDRAM_DQM during that beat is the inverse of the matching strobe slice.
  - Output enable is high only in cycles N+1 .. N+RATIO.
- DQM outside write beats:
  - During expected read-data cycles, SDRAM_DQM = 0.
  - In all other cycles, SDRAM_DQM is all-ones.
- Read path (cmd_read_i at cycle N):
  - Beat k is expected on DQ during cycle N+1+CAS_LATENCY+k and is sampled at the end of that cycle into slice k of the assembly register.
  - rd_valid_o pulses in cycle N+CAS_LATENCY+RATIO+1, with rd_data_o holding the full word.
  - rd_data_o holds its value until the next rd_valid_o.
  - Multiple reads may be in flight; they are tracked by a valid/beat-index shift pipeline of depth CAS_LATENCY+RATIO+1.
- Issue rules:
  - rd_ready_o = no write beat is scheduled for the next cycle AND at least RATIO cycles have passed since the last accepted read.
  - wr_ready_o = no read is in flight (the last read's rd_valid_o cycle or later) AND no write beat is scheduled for the next cycle. The read-to-write gap guarantees at least one turnaround cycle before driving DQ.
  - Back-to-back writes spaced RATIO cycles apart give continuous beats.
- Violations:
  - A command pulsed while its ready is low is ignored: no DQ drive, no capture; err_o is set.
  - If cmd_read_i and cmd_write_i are high in the same cycle, both are ignored and err_o is set.
- Width rules:
  - Beat 0 is the least-significant slice.
  - When RATIO = 1 the beat counters collapse; one beat per command.

Decomposition:
- Package sdram_pkg:
  - RATIO and DQM_W = DQ_WIDTH/8 derivation functions.
  - Legal CAS latency constants.
  - Read-pipeline entry typedef (valid, beat index).
- One natural sub-module, sdram_rd_capture: the read pipeline, beat sampling, assembly register and rd_valid_o.
- Write serialiser, ready logic and tri-state stay in the top level.

Test Plan:
All scenarios use DATA_WIDTH=32, DQ_WIDTH=16, CAS_LATENCY=2 unless stated.
1. Full write: cmd_write_i at cycle 0, wr_data_i=0xDEADBEEF, wr_strb_i=4'hF -> DQ=0xBEEF in cycle 1 and 0xDEAD in cycle 2; DQM=2'b00; DQ high-Z in cycles 0 and 3.
2. Partial write: wr_strb_i=4'b0100, data 0xAABBCCDD -> beat 0 DQM=2'b11; beat 1 DQ=0xAABB, DQM=2'b10.
3. Single read: cmd_read_i at cycle 0; model drives 0x1234 in cycle 3 and 0x5678 in cycle 4 -> rd_valid_o in cycle 5 only, rd_data_o=0x56781234; DQ never driven by the DUT.
4. Pipelined reads and CL3:
   - Reads at cycles 0 and 2 -> rd_valid_o at cycles 5 and 7 with the correct words.
   - A read at cycle 1 -> ignored, err_o=1.
   - Repeat with CAS_LATENCY=3 -> valids at cycles 6 and 8.
5. Turnaround:
   - Read at 0, then write pulsed at 3 -> ignored, err_o=1, DQ stays high-Z.
   - Write pulsed at 5 -> accepted, beats in cycles 6 and 7.
6. Reset mid-write: HRESETn low in cycle 1 of a write -> DQ high-Z asynchronously; DQM=all-ones; rd_valid_o=0; after release wr_ready_o=1 and no beat appears.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM data path: width derivation,
// legal CAS latencies and the read-pipeline entry.
package sdram_pkg;

    localparam int CL_MIN = 2;
    localparam int CL_MAX = 3;

    // Wide enough for the largest legal word/DQ ratio of 4
    localparam int BEAT_W = 2;

    typedef logic [BEAT_W-1:0] beat_idx_t;

    typedef struct packed {
        logic      valid;
        beat_idx_t beat;
    } rd_pipe_t;

    function automatic int calc_ratio(input int data_w, input int dq_w);
        return data_w / dq_w;
    endfunction

    function automatic int calc_dqm_w(input int dq_w);
        return dq_w / 8;
    endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// Read pipeline: tracks in-flight READs, samples DQ beats after the CAS
// latency, reassembles them into one word and pulses rd_valid_o.
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DQ_WIDTH    = 16,
    parameter int CAS_LATENCY = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  rd_start,
    input  logic [DQ_WIDTH-1:0]   dq_in,
    output logic                  rd_window,
    output logic                  rd_recent,
    output logic                  rd_busy,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o
);

    localparam int RATIO = calc_ratio(DATA_WIDTH, DQ_WIDTH);
    localparam int DEPTH = CAS_LATENCY + RATIO + 1;
    localparam int LAST  = CAS_LATENCY + RATIO - 1;

    rd_pipe_t              pipe_q [DEPTH];
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_next;
    logic                  cap_en;
    beat_idx_t             cap_beat;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        cap_en    = 1'b0;
        cap_beat  = '0;
        rd_recent = 1'b0;
        rd_busy   = 1'b0;
        for (int s = CAS_LATENCY; s <= LAST; s++) begin
            if (pipe_q[s].valid) begin
                cap_en   = 1'b1;
                cap_beat = pipe_q[s].beat;
            end
        end
        for (int s = 0; s < RATIO - 1; s++) begin
            rd_recent = rd_recent | pipe_q[s].valid;
        end
        for (int s = 0; s <= LAST; s++) begin
            rd_busy = rd_busy | pipe_q[s].valid;
        end
        asm_next = asm_q;
        asm_next[int'(cap_beat)*DQ_WIDTH +: DQ_WIDTH] = dq_in;
    end

    // NOTE: the whole pipeline is reset, not just flagged, so a reset mid-read emits nothing.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int s = 0; s < DEPTH; s++) begin
                pipe_q[s] <= '0;
            end
            asm_q     <= '0;
            rd_data_o <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage shift on the same edge.
            pipe_q[0] <= '{valid: rd_start, beat: '0};
            for (int s = 1; s < DEPTH; s++) begin
                pipe_q[s].valid <= pipe_q[s-1].valid;
                pipe_q[s].beat  <= (s - 1 >= CAS_LATENCY) ? pipe_q[s-1].beat + 1'b1
                                                          : pipe_q[s-1].beat;
            end
            if (cap_en) begin
                asm_q <= asm_next;
            end
            if (pipe_q[LAST].valid) begin
                rd_data_o <= asm_next;
            end
        end
    end

    assign rd_window  = cap_en;
    assign rd_valid_o = pipe_q[DEPTH-1].valid;

endmodule

// File: rtl/sdram_dq_path.sv
// SDRAM DQ data path: write serialiser with per-beat DQM, tri-state control,
// issue/turnaround rules for the command FSM, and the read capture pipeline.
module sdram_dq_path
    import sdram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DQ_WIDTH    = 16,
    parameter int CAS_LATENCY = 2
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    cmd_write_i,
    input  logic                    cmd_read_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    output logic                    wr_ready_o,
    output logic                    rd_ready_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    output logic                    err_o,
    inout  wire  [DQ_WIDTH-1:0]     SDRAM_DQ,
    output logic [DQ_WIDTH/8-1:0]   SDRAM_DQM
);

    localparam int RATIO  = calc_ratio(DATA_WIDTH, DQ_WIDTH);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int DQM_W  = calc_dqm_w(DQ_WIDTH);
    localparam int CNT_W  = $clog2(RATIO + 1);

    if ((DATA_WIDTH % 8 != 0) || (DQ_WIDTH % 8 != 0) || (DATA_WIDTH % DQ_WIDTH != 0) ||
        !(RATIO == 1 || RATIO == 2 || RATIO == 4) ||
        (CAS_LATENCY != CL_MIN && CAS_LATENCY != CL_MAX)) begin : g_bad_params
        $error("sdram_dq_path: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [STRB_W-1:0]     wr_strb_q;
    logic [CNT_W-1:0]      wr_cnt_q;
    logic                  err_q;
    logic                  dq_oe;
    logic                  wr_more;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  cmd_bad;
    logic                  rd_window;
    logic                  rd_recent;
    logic                  rd_busy;

    assign dq_oe   = (wr_cnt_q != '0);
    assign wr_more = (wr_cnt_q > CNT_W'(1));

    // A read only blocks writes until its rd_valid_o cycle, which leaves one idle turnaround cycle
    assign wr_ready_o = !rd_busy && !wr_more;
    assign rd_ready_o = !rd_recent && !wr_more;

    assign wr_acc  = cmd_write_i && !cmd_read_i && wr_ready_o;
    assign rd_acc  = cmd_read_i && !cmd_write_i && rd_ready_o;
    assign cmd_bad = (cmd_write_i && cmd_read_i) ||
                     (cmd_write_i && !wr_ready_o) ||
                     (cmd_read_i && !rd_ready_o);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_data_q <= '0;
            wr_strb_q <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_data_q <= wr_data_i;
                wr_strb_q <= wr_strb_i;
                wr_cnt_q  <= CNT_W'(RATIO);
            end else if (dq_oe) begin
                wr_data_q <= wr_data_q >> DQ_WIDTH;
                wr_strb_q <= wr_strb_q >> DQM_W;
                wr_cnt_q  <= wr_cnt_q - 1'b1;
            end
            if (cmd_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        SDRAM_DQM = '1;
        if (dq_oe) begin
            SDRAM_DQM = ~wr_strb_q[DQM_W-1:0];
        end else if (rd_window) begin
            SDRAM_DQM = '0;
        end
    end

    // Output enable comes straight from an async-reset flop, so DQ floats the moment reset asserts
    assign SDRAM_DQ = dq_oe ? wr_data_q[DQ_WIDTH-1:0] : {DQ_WIDTH{1'bz}};
    assign err_o    = err_q;

    sdram_rd_capture #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DQ_WIDTH    (DQ_WIDTH),
        .CAS_LATENCY (CAS_LATENCY)
    ) u_rd_capture (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .rd_start   (rd_acc),
        .dq_in      (SDRAM_DQ),
        .rd_window  (rd_window),
        .rd_recent  (rd_recent),
        .rd_busy    (rd_busy),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o)
    );

endmodule

// File: tb/tb_sdram_dq_path.sv
// Directed bench for sdram_dq_path: a CL2 instance for most scenarios and a
// CL3 instance for the latency variant; the bench plays the SDRAM on DQ.
module tb_sdram_dq_path;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_write;
    logic        cmd_read;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    logic        wr_ready2, rd_ready2, rd_valid2, err2;
    logic [31:0] rd_data2;
    logic [1:0]  dqm2;
    wire  [15:0] dq2;
    logic        tb_en2;
    logic [15:0] tb_val2;

    logic        wr_ready3, rd_ready3, rd_valid3, err3;
    logic [31:0] rd_data3;
    logic [1:0]  dqm3;
    wire  [15:0] dq3;
    logic        tb_en3;
    logic [15:0] tb_val3;

    int checks   = 0;
    int failures = 0;

    assign dq2 = tb_en2 ? tb_val2 : 16'hzzzz;
    assign dq3 = tb_en3 ? tb_val3 : 16'hzzzz;

    always #5 HCLK = ~HCLK;

    sdram_dq_path #(.DATA_WIDTH(32), .DQ_WIDTH(16), .CAS_LATENCY(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .cmd_write_i(cmd_write), .cmd_read_i(cmd_read),
        .wr_data_i(wr_data), .wr_strb_i(wr_strb), .wr_ready_o(wr_ready2), .rd_ready_o(rd_ready2),
        .rd_data_o(rd_data2), .rd_valid_o(rd_valid2), .err_o(err2), .SDRAM_DQ(dq2), .SDRAM_DQM(dqm2)
    );

    sdram_dq_path #(.DATA_WIDTH(32), .DQ_WIDTH(16), .CAS_LATENCY(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .cmd_write_i(cmd_write), .cmd_read_i(cmd_read),
        .wr_data_i(wr_data), .wr_strb_i(wr_strb), .wr_ready_o(wr_ready3), .rd_ready_o(rd_ready3),
        .rd_data_o(rd_data3), .rd_valid_o(rd_valid3), .err_o(err3), .SDRAM_DQ(dq3), .SDRAM_DQM(dqm3)
    );

    // Cycle c starts 1 time unit after posedge c; outputs are sampled on the following negedge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        cmd_write = 1'b0;
        cmd_read  = 1'b0;
        tb_en2    = 1'b0;
        tb_en3    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        idle(0);
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        cmd_write = 1'b0; cmd_read = 1'b0; wr_data = '0; wr_strb = '0;
        tb_en2 = 1'b0; tb_val2 = '0; tb_en3 = 1'b0; tb_val3 = '0;
        HRESETn = 1'b0;
        #2;
        checks++; if (dut2.dq_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", dut2.dq_oe); end
        checks++; if (dqm2 !== 2'b11) begin failures++; $display("FAIL reset_dqm got=%b exp=11", dqm2); end
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        checks++; if (wr_ready2 !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready2); end
        checks++; if (rd_ready2 !== 1'b1) begin failures++; $display("FAIL reset_rd_ready got=%b exp=1", rd_ready2); end
        checks++; if (rd_valid2 !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid2); end
        checks++; if (rd_data2 !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data2); end
        checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err2); end
    endtask

    task automatic test_write(input string name, input logic [31:0] d, input logic [3:0] s,
                              input logic [15:0] b0, input logic [15:0] b1,
                              input logic [1:0] m0, input logic [1:0] m1);
        logic        exp_oe;
        logic [15:0] exp_dq;
        logic [1:0]  exp_dqm;
        logic        exp_rdy;
        for (int c = 0; c < 4; c++) begin
            tick();
            cmd_write = (c == 0);
            wr_data   = d;
            wr_strb   = s;
            @(negedge HCLK);
            exp_oe  = (c == 1) || (c == 2);
            exp_dq  = (c == 1) ? b0 : b1;
            exp_dqm = (c == 1) ? m0 : (c == 2) ? m1 : 2'b11;
            exp_rdy = (c != 1);
            checks++; if (dut2.dq_oe !== exp_oe) begin failures++; $display("FAIL %s_oe c%0d got=%b exp=%b", name, c, dut2.dq_oe, exp_oe); end
            if (exp_oe) begin
                checks++; if (dq2 !== exp_dq) begin failures++; $display("FAIL %s_dq c%0d got=%h exp=%h", name, c, dq2, exp_dq); end
            end
            checks++; if (dqm2 !== exp_dqm) begin failures++; $display("FAIL %s_dqm c%0d got=%b exp=%b", name, c, dqm2, exp_dqm); end
            checks++; if (wr_ready2 !== exp_rdy) begin failures++; $display("FAIL %s_wr_ready c%0d got=%b exp=%b", name, c, wr_ready2, exp_rdy); end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [15:0] beats [4];
        beats = '{16'h3333, 16'h4444, 16'h5555, 16'h6666};
        for (int c = 0; c < 6; c++) begin
            tick();
            cmd_write = (c == 0) || (c == 2);
            wr_data   = (c == 0) ? 32'h4444_3333 : 32'h6666_5555;
            wr_strb   = 4'hF;
            @(negedge HCLK);
            checks++; if (dut2.dq_oe !== (c >= 1 && c <= 4)) begin failures++; $display("FAIL b2b_oe c%0d got=%b", c, dut2.dq_oe); end
            if (c >= 1 && c <= 4) begin
                checks++; if (dq2 !== beats[c-1]) begin failures++; $display("FAIL b2b_dq c%0d got=%h exp=%h", c, dq2, beats[c-1]); end
            end
        end
        checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", err2); end
        idle(2);
    endtask

    task automatic test_single_read();
        for (int c = 0; c < 7; c++) begin
            tick();
            cmd_read = (c == 0);
            tb_en2   = (c == 3) || (c == 4);
            tb_val2  = (c == 3) ? 16'h1234 : 16'h5678;
            @(negedge HCLK);
            checks++; if (dut2.dq_oe !== 1'b0) begin failures++; $display("FAIL rd1_oe c%0d got=%b exp=0", c, dut2.dq_oe); end
            checks++; if (rd_valid2 !== (c == 5)) begin failures++; $display("FAIL rd1_valid c%0d got=%b exp=%b", c, rd_valid2, (c == 5)); end
            checks++; if (dqm2 !== ((c == 3 || c == 4) ? 2'b00 : 2'b11)) begin failures++; $display("FAIL rd1_dqm c%0d got=%b", c, dqm2); end
            if (c >= 1 && c <= 5) begin
                checks++; if (wr_ready2 !== (c == 5)) begin failures++; $display("FAIL rd1_wr_ready c%0d got=%b exp=%b", c, wr_ready2, (c == 5)); end
            end
            if (c == 1) begin
                checks++; if (rd_ready2 !== 1'b0) begin failures++; $display("FAIL rd1_rd_ready c1 got=%b exp=0", rd_ready2); end
            end
            if (c == 5) begin
                checks++; if (rd_data2 !== 32'h5678_1234) begin failures++; $display("FAIL rd1_data got=%h exp=56781234", rd_data2); end
            end
        end
        idle(2);
    endtask

    task automatic test_pipelined_reads();
        logic [15:0] drv [4];
        drv = '{16'hF00D, 16'hCAFE, 16'h9BDF, 16'h1357};
        for (int c = 0; c < 9; c++) begin
            tick();
            cmd_read = (c <= 2);
            tb_en2   = (c >= 3) && (c <= 6);
            tb_val2  = (c >= 3 && c <= 6) ? drv[c-3] : 16'h0;
            @(negedge HCLK);
            checks++; if (rd_valid2 !== (c == 5 || c == 7)) begin failures++; $display("FAIL rdp_valid c%0d got=%b", c, rd_valid2); end
            if (c == 1) begin
                checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL rdp_err c1 got=%b exp=0", err2); end
                checks++; if (rd_ready2 !== 1'b0) begin failures++; $display("FAIL rdp_rd_ready c1 got=%b exp=0", rd_ready2); end
            end
            if (c == 2) begin
                checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL rdp_err c2 got=%b exp=1", err2); end
            end
            if (c == 5) begin
                checks++; if (rd_data2 !== 32'hCAFE_F00D) begin failures++; $display("FAIL rdp_data0 got=%h exp=cafef00d", rd_data2); end
            end
            if (c == 7) begin
                checks++; if (rd_data2 !== 32'h1357_9BDF) begin failures++; $display("FAIL rdp_data1 got=%h exp=13579bdf", rd_data2); end
            end
        end
        idle(2);
    endtask

    task automatic test_cl3();
        logic [15:0] drv [4];
        drv = '{16'hF00D, 16'hCAFE, 16'h9BDF, 16'h1357};
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            cmd_read = (c == 0) || (c == 2);
            tb_en3   = (c >= 4) && (c <= 7);
            tb_val3  = (c >= 4 && c <= 7) ? drv[c-4] : 16'h0;
            @(negedge HCLK);
            checks++; if (rd_valid3 !== (c == 6 || c == 8)) begin failures++; $display("FAIL cl3_valid c%0d got=%b", c, rd_valid3); end
            checks++; if (dqm3 !== ((c >= 4 && c <= 7) ? 2'b00 : 2'b11)) begin failures++; $display("FAIL cl3_dqm c%0d got=%b", c, dqm3); end
            if (c == 6) begin
                checks++; if (rd_data3 !== 32'hCAFE_F00D) begin failures++; $display("FAIL cl3_data0 got=%h exp=cafef00d", rd_data3); end
            end
            if (c == 8) begin
                checks++; if (rd_data3 !== 32'h1357_9BDF) begin failures++; $display("FAIL cl3_data1 got=%h exp=13579bdf", rd_data3); end
            end
        end
        checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL cl3_err got=%b exp=0", err3); end
        idle(2);
    endtask

    task automatic test_turnaround();
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            tick();
            cmd_read  = (c == 0);
            cmd_write = (c == 3) || (c == 5);
            wr_data   = (c == 3) ? 32'h9988_7766 : 32'h1122_3344;
            wr_strb   = 4'hF;
            @(negedge HCLK);
            checks++; if (dut2.dq_oe !== (c == 6 || c == 7)) begin failures++; $display("FAIL turn_oe c%0d got=%b", c, dut2.dq_oe); end
            if (c == 3) begin
                checks++; if (wr_ready2 !== 1'b0) begin failures++; $display("FAIL turn_wr_ready c3 got=%b exp=0", wr_ready2); end
                checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL turn_err c3 got=%b exp=0", err2); end
            end
            if (c == 4) begin
                checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL turn_err c4 got=%b exp=1", err2); end
            end
            if (c == 5) begin
                checks++; if (wr_ready2 !== 1'b1) begin failures++; $display("FAIL turn_wr_ready c5 got=%b exp=1", wr_ready2); end
            end
            if (c == 6) begin
                checks++; if (dq2 !== 16'h3344) begin failures++; $display("FAIL turn_dq c6 got=%h exp=3344", dq2); end
            end
            if (c == 7) begin
                checks++; if (dq2 !== 16'h1122) begin failures++; $display("FAIL turn_dq c7 got=%h exp=1122", dq2); end
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid_write();
        tick();
        cmd_write = 1'b1;
        wr_data   = 32'hDEAD_BEEF;
        wr_strb   = 4'hF;
        tick();
        cmd_write = 1'b0;
        checks++; if (dut2.dq_oe !== 1'b1) begin failures++; $display("FAIL rstw_oe_before got=%b exp=1", dut2.dq_oe); end
        #1 HRESETn = 1'b0;
        #1;
        checks++; if (dut2.dq_oe !== 1'b0) begin failures++; $display("FAIL rstw_oe_async got=%b exp=0", dut2.dq_oe); end
        checks++; if (dqm2 !== 2'b11) begin failures++; $display("FAIL rstw_dqm got=%b exp=11", dqm2); end
        checks++; if (rd_valid2 !== 1'b0) begin failures++; $display("FAIL rstw_rd_valid got=%b exp=0", rd_valid2); end
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge HCLK);
            checks++; if (dut2.dq_oe !== 1'b0) begin failures++; $display("FAIL rstw_oe_after c%0d got=%b exp=0", c, dut2.dq_oe); end
            checks++; if (wr_ready2 !== 1'b1) begin failures++; $display("FAIL rstw_wr_ready c%0d got=%b exp=1", c, wr_ready2); end
            checks++; if (dqm2 !== 2'b11) begin failures++; $display("FAIL rstw_dqm_after c%0d got=%b exp=11", c, dqm2); end
            checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL rstw_err c%0d got=%b exp=0", c, err2); end
        end
    endtask

    initial begin
        test_reset();
        test_write("wr_full", 32'hDEAD_BEEF, 4'hF, 16'hBEEF, 16'hDEAD, 2'b00, 2'b00);
        test_write("wr_part", 32'hAABB_CCDD, 4'b0100, 16'hCCDD, 16'hAABB, 2'b11, 2'b10);
        test_back_to_back();
        test_single_read();
        test_pipelined_reads();
        test_cl3();
        test_turnaround();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
